// File: rtl/jtframe_rstseq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_rstseq_pkg
//  Description : Shared types and constants for the reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtframe_rstseq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        SDRAM_RST  = 3'd1,
        SDRAM_INIT = 3'd2,
        GAME_RST   = 3'd3,
        RUN        = 3'd4
    } rstseq_st_t;

    localparam logic [1:0] RETRY_MAX = 2'd3;

    // Width of a counter that runs 0..limit-1; never narrower than one bit
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_sync2
//  Description : Two-flop synchronizer for a single asynchronous level.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            o_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtframe_rstseq.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_rstseq
//  Description : PLL-lock / SDRAM-init reset sequencer with game clock enable.
//                Define JTFRAME_RSTSEQ_WDOG_EN to enable the SDRAM init watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_rstseq
    import jtframe_rstseq_pkg::*;
#(
    parameter int LOCK_STABLE  = 1024,
    parameter int SDRAM_HOLD   = 16,
    parameter int GAME_HOLD    = 256,
    parameter int INIT_TIMEOUT = 65536,
    parameter int CENDIV       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sdram_init_done,
    output logic       sdram_rst,
    output logic       game_rst,
    output logic       cen,
    output logic       ready,
    output logic [1:0] retries
);

    localparam int c_cnt_w = max2(cnt_width(LOCK_STABLE),
                                  max2(cnt_width(SDRAM_HOLD), cnt_width(GAME_HOLD)));
    localparam int c_div_w = cnt_width(CENDIV);

    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_lock_last = c_cnt_w'(LOCK_STABLE - 1);
    localparam logic [c_cnt_w-1:0] c_sdr_last  = c_cnt_w'(SDRAM_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_game_last = c_cnt_w'(GAME_HOLD - 1);
    localparam logic [c_div_w-1:0] c_div_one   = c_div_w'(1);
    localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(CENDIV - 1);

    generate
        if (CENDIV < 2 || LOCK_STABLE < 1 || SDRAM_HOLD < 1 ||
            GAME_HOLD < 1 || INIT_TIMEOUT < 1) begin : g_param_check
            $error("jtframe_rstseq: invalid parameter value");
        end
    endgenerate

    rstseq_st_t         r_st;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_div_w-1:0] r_div;
    logic [c_div_w-1:0] w_div_nxt;
    logic               w_lk;
    logic               w_timeout;

    jtframe_sync2 u_sync_lock (
        .clk (clk),
        .rst (rst),
        .i_d (pll_locked),
        .o_q (w_lk)
    );

    assign w_div_nxt = (r_div == c_div_last) ? '0 : r_div + c_div_one;

`ifdef JTFRAME_RSTSEQ_WDOG_EN
    localparam int c_wdog_w = cnt_width(INIT_TIMEOUT);
    localparam logic [c_wdog_w-1:0] c_wdog_one  = c_wdog_w'(1);
    localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(INIT_TIMEOUT - 1);

    logic [c_wdog_w-1:0] r_wdog;

    // Runs only while genuinely waiting in SDRAM_INIT, so it is zero on every entry
    always_ff @(posedge clk) begin
        if (rst || !w_lk || r_st != SDRAM_INIT || sdram_init_done || w_timeout) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + c_wdog_one;
        end
    end

    assign w_timeout = (r_st == SDRAM_INIT) && (r_wdog == c_wdog_last);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st      <= WAIT_LOCK;
            r_cnt     <= '0;
            r_div     <= '0;
            sdram_rst <= 1'b1;
            game_rst  <= 1'b1;
            cen       <= 1'b0;
            ready     <= 1'b0;
            retries   <= '0;
        end else if (!w_lk) begin
            // Lock loss wins over everything else; retries are preserved
            r_st      <= WAIT_LOCK;
            r_cnt     <= '0;
            sdram_rst <= 1'b1;
            game_rst  <= 1'b1;
            cen       <= 1'b0;
            ready     <= 1'b0;
        end else begin
            case (r_st)
                WAIT_LOCK: begin
                    if (r_cnt == c_lock_last) begin
                        r_st  <= SDRAM_RST;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                SDRAM_RST: begin
                    if (r_cnt == c_sdr_last) begin
                        r_st      <= SDRAM_INIT;
                        r_cnt     <= '0;
                        sdram_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                SDRAM_INIT: begin
                    if (sdram_init_done) begin
                        r_st  <= GAME_RST;
                        r_div <= '0;
                        cen   <= 1'b1;
                    end else if (w_timeout) begin
                        r_st      <= SDRAM_RST;
                        sdram_rst <= 1'b1;
                        if (retries != RETRY_MAX) begin
                            retries <= retries + 2'd1;
                        end
                    end
                end
                GAME_RST: begin
                    r_div <= w_div_nxt;
                    cen   <= (w_div_nxt == '0);
                    if (r_cnt == c_game_last) begin
                        r_st     <= RUN;
                        r_cnt    <= '0;
                        game_rst <= 1'b0;
                        ready    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                RUN: begin
                    r_div <= w_div_nxt;
                    cen   <= (w_div_nxt == '0);
                end
                default: begin
                    r_st      <= WAIT_LOCK;
                    r_cnt     <= '0;
                    sdram_rst <= 1'b1;
                    game_rst  <= 1'b1;
                    cen       <= 1'b0;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
